// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
// Instruction-fetch front end for the MIPS datapath. Owns the fetch PC,
// issues one word read at a time to instruction memory (req/ack), and
// buffers returned words tagged with their PC in a DEPTH-entry FIFO that
// the datapath pops with valid/ready. A redirect flushes the FIFO and
// retargets fetch; a read already in flight is completed and its data dropped.
//
// Ports
//   clock, reset_n             clock (rising edge), async active-low reset
//   imem_req/imem_addr         registered fetch request, word aligned
//   imem_ack/imem_rdata        memory returns data for the pending request
//   redirect/redirect_pc       taken branch/jump, target low bits forced to 0
//   instr_valid/instr/instr_pc FIFO head (registered, holds when empty)
//   instr_ready                head consumed when valid & ready
//   fifo_count                 occupied entries 0..DEPTH
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int         CW       = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          instr_valid,
  output logic [31:0]   instr,
  output logic [31:0]   instr_pc,
  input  logic          instr_ready,
  output logic [CW-1:0] fifo_count
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_req;
  logic [31:0]             r_addr;
  logic [31:0]             r_fetch_pc, w_fetch_nxt;
  logic [CW-1:0]           r_count, w_cnt_nxt;
  logic [AW-1:0]           r_rd, r_wr, w_rd_inc;
  logic [DEPTH-1:0][31:0]  r_mem_d, r_mem_pc;
  logic [31:0]             r_head_d, r_head_pc;
  logic [31:0]             w_tgt, w_head_d, w_head_pc;
  logic                    w_push, w_pop, w_issue, w_head_ld;

  assign w_tgt    = redirect_pc & 32'hFFFF_FFFC;
  assign w_rd_inc = r_rd + 1'b1;

  always_comb begin
    // Redirect beats both push and pop: the flush discards everything.
    w_pop       = instr_valid & instr_ready & ~redirect;
    w_push      = (r_state == S_WAIT) & imem_ack & ~redirect;
    w_cnt_nxt   = r_count;
    if (redirect)
      w_cnt_nxt = '0;
    else if (w_push && !w_pop)
      w_cnt_nxt = r_count + 1'b1;
    else if (!w_push && w_pop)
      w_cnt_nxt = r_count - 1'b1;

    w_fetch_nxt = r_fetch_pc;
    if (redirect)
      w_fetch_nxt = w_tgt;
    else if (w_push)
      w_fetch_nxt = r_fetch_pc + 32'd4;

    // Every issue targets w_fetch_nxt: current PC from IDLE/DROP,
    // PC+4 for a back-to-back issue after a push.
    w_issue     = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!redirect && r_count < FULL) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT, S_DROP: begin
        if (imem_ack) begin
          if (!redirect && w_cnt_nxt < FULL) begin
            w_issue     = 1'b1;
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (redirect) begin
          w_state_nxt = S_DROP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Head registers follow the entry that will sit at the read pointer
    // after this edge; they hold their old value whenever the FIFO is empty.
    w_head_ld = 1'b0;
    w_head_d  = r_head_d;
    w_head_pc = r_head_pc;
    if (!redirect && w_cnt_nxt != '0) begin
      if (r_count == '0 || (r_count == CW'(1) && w_pop)) begin
        w_head_ld = 1'b1;
        w_head_d  = imem_rdata;
        w_head_pc = r_fetch_pc;
      end else if (w_pop) begin
        w_head_ld = 1'b1;
        w_head_d  = r_mem_d[w_rd_inc];
        w_head_pc = r_mem_pc[w_rd_inc];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_head_d   <= '0;
      r_head_pc  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= (w_state_nxt != S_IDLE);
      if (w_issue)
        r_addr   <= w_fetch_nxt;
      r_fetch_pc <= w_fetch_nxt;
      r_count    <= w_cnt_nxt;
      if (redirect) begin
        r_rd     <= '0;
        r_wr     <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + 1'b1;
        if (w_pop)  r_rd <= w_rd_inc;
      end
      if (w_head_ld) begin
        r_head_d  <= w_head_d;
        r_head_pc <= w_head_pc;
      end
    end
  end

  // Payload storage needs no reset; only entries below fifo_count are read.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_d[r_wr]  <= imem_rdata;
      r_mem_pc[r_wr] <= r_fetch_pc;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr_valid = (r_count != '0);
  assign instr       = r_head_d;
  assign instr_pc    = r_head_pc;
  assign fifo_count  = r_count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue. Stimulus pushes expected PCs into
// a queue; a negedge monitor pops and compares on every valid&ready pop.
// A second instance with RESET_PC=FFFFFFF8 checks PC wrap-around.
module tb_instr_fetch_queue;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;
  logic        instr_ready = 1'b0;
  logic [2:0]  fifo_count;

  logic        m_ack = 1'b0, man_ack = 1'b0;
  logic [31:0] m_rdata = 32'h0, man_rdata = 32'h0;
  bit          mem_en = 1'b0;

  logic        rst2_n = 1'b0;
  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc2;
  logic [2:0]  cnt2;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_pc[$];
  logic [31:0] wrapv[4];

  assign imem_ack   = m_ack | man_ack;
  assign imem_rdata = man_ack ? man_rdata : m_rdata;

  always #5 clock = ~clock;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fifo_count(fifo_count)
  );

  // Zero-wait memory: ack combinationally whenever a request is up.
  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clock(clock), .reset_n(rst2_n),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(req2), .imem_rdata(f(addr2)),
    .redirect(1'b0), .redirect_pc(32'h0),
    .instr_valid(valid2), .instr(instr2), .instr_pc(pc2),
    .instr_ready(1'b1), .fifo_count(cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Memory model: acks in the first cycle a request is visible.
  always @(posedge clock) begin
    #1;
    m_ack = 1'b0;
    if (mem_en && imem_req) begin
      m_ack   = 1'b1;
      m_rdata = f(imem_addr);
    end
  end

  // Monitor: scoreboard pops and request-stability check.
  logic        p_req = 1'b0, p_ack = 1'b0;
  logic [31:0] p_addr = 32'h0;
  always @(negedge clock) begin
    if (reset_n && instr_valid && instr_ready && !redirect) begin
      if (exp_pc.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc %h expected none", instr_pc);
      end else begin
        logic [31:0] e;
        e = exp_pc.pop_front();
        chk("pop_pc", instr_pc, e);
        chk("pop_instr", instr, f(e));
      end
    end
    if (reset_n && p_req && !p_ack && imem_req)
      chk("addr_stable", imem_addr, p_addr);
    p_req  = imem_req & reset_n;
    p_ack  = imem_ack;
    p_addr = imem_addr;
  end

  initial begin
    wrapv[0] = 32'hFFFF_FFF8; wrapv[1] = 32'hFFFF_FFFC;
    wrapv[2] = 32'h0000_0000; wrapv[3] = 32'h0000_0004;

    // 1: reset state, reset mid-WAIT, late ack ignored
    tick(); tick();
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_count", {29'b0, fifo_count}, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    reset_n = 1'b1;
    tick();
    chk("t1_req", {31'b0, imem_req}, 32'h1);
    chk("t1_addr", imem_addr, 32'h0);
    tick();
    reset_n = 1'b0;
    #1;
    chk("t1_midrst_req", {31'b0, imem_req}, 32'h0);
    chk("t1_midrst_cnt", {29'b0, fifo_count}, 32'h0);
    man_ack = 1'b1; man_rdata = 32'hDEAD_0001;
    tick();
    reset_n = 1'b1;
    tick();
    man_ack = 1'b0;
    chk("t1_late_cnt", {29'b0, fifo_count}, 32'h0);
    chk("t1_late_req", {31'b0, imem_req}, 32'h1);
    chk("t1_late_addr", imem_addr, 32'h0);

    // 2: streaming from reset, one word per cycle
    reset_n = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) exp_pc.push_back(32'(i * 4));
    mem_en = 1'b1; instr_ready = 1'b1;
    reset_n = 1'b1;
    tick();
    chk("t2_valid_early", {31'b0, instr_valid}, 32'h0);
    tick();
    chk("t2_first_valid", {31'b0, instr_valid}, 32'h1);
    chk("t2_first_pc", instr_pc, 32'h0);
    for (int k = 1; k < 8; k++) begin
      if (k == 7) mem_en = 1'b0;
      tick();
      chk("t2_stream_valid", {31'b0, instr_valid}, 32'h1);
      chk("t2_stream_pc", instr_pc, 32'(k * 4));
    end
    tick();
    chk("t2_empty", {29'b0, fifo_count}, 32'h0);
    chk("t2_pend_addr", imem_addr, 32'h20);

    // 3: backpressure fills exactly DEPTH entries
    instr_ready = 1'b0; mem_en = 1'b1;
    repeat (7) tick();
    chk("t3_full", {29'b0, fifo_count}, 32'h4);
    chk("t3_req", {31'b0, imem_req}, 32'h0);
    chk("t3_head", instr_pc, 32'h20);
    mem_en = 1'b0; instr_ready = 1'b1;
    repeat (6) tick();
    chk("t3_drained", {29'b0, fifo_count}, 32'h0);
    chk("t3_sb_empty", 32'(exp_pc.size()), 32'h0);

    // 4: redirect while WAIT -> DROP
    instr_ready = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; redirect = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect = 1'b0;
    chk("t4_idle_redir_req", {31'b0, imem_req}, 32'h0);
    tick();
    chk("t4_req10", {31'b0, imem_req}, 32'h1);
    chk("t4_addr10", imem_addr, 32'h10);
    redirect = 1'b1; redirect_pc = 32'h400;
    tick();
    redirect = 1'b0;
    chk("t4_drop_addr", imem_addr, 32'h10);
    tick(); tick();
    man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
    tick();
    man_ack = 1'b0;
    chk("t4_drop_cnt", {29'b0, fifo_count}, 32'h0);
    chk("t4_new_req", {31'b0, imem_req}, 32'h1);
    chk("t4_new_addr", imem_addr, 32'h400);
    mem_en = 1'b1;
    repeat (6) tick();
    chk("t4_cnt", {29'b0, fifo_count}, 32'h4);
    chk("t4_head_pc", instr_pc, 32'h400);
    chk("t4_head_instr", instr, f(32'h400));

    // 5: redirect with pop, then redirect with ack
    mem_en = 1'b0; instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h503;
    tick();
    redirect = 1'b0; instr_ready = 1'b0;
    chk("t5_pop_flush_cnt", {29'b0, fifo_count}, 32'h0);
    chk("t5_pop_flush_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    chk("t5_addr500", imem_addr, 32'h500);
    man_ack = 1'b1; man_rdata = 32'hBAD0_BAD0; redirect = 1'b1; redirect_pc = 32'h403;
    tick();
    man_ack = 1'b0; redirect = 1'b0;
    chk("t5_ack_flush_cnt", {29'b0, fifo_count}, 32'h0);
    chk("t5_ack_flush_valid", {31'b0, instr_valid}, 32'h0);
    chk("t5_ack_idle_req", {31'b0, imem_req}, 32'h0);
    tick();
    chk("t5_req400", {31'b0, imem_req}, 32'h1);
    chk("t5_addr400", imem_addr, 32'h400);
    for (int i = 0; i < 4; i++) exp_pc.push_back(32'h400 + 32'(i * 4));
    mem_en = 1'b1;
    repeat (7) tick();
    chk("t5_cnt", {29'b0, fifo_count}, 32'h4);
    mem_en = 1'b0; instr_ready = 1'b1;
    repeat (6) tick();
    chk("t5_drained", {29'b0, fifo_count}, 32'h0);
    chk("t5_sb_empty", 32'(exp_pc.size()), 32'h0);

    // 6: PC wrap on the second instance
    rst2_n = 1'b1;
    tick();
    chk("t6_valid_early", {31'b0, valid2}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_valid", {31'b0, valid2}, 32'h1);
      chk("t6_pc", pc2, wrapv[k]);
      chk("t6_instr", instr2, f(wrapv[k]));
      chk("t6_cnt", {29'b0, cnt2}, 32'h1);
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
